// File: rtl/nand_resp_checker.sv
// nand_resp_checker: drives a fixed-length run of NAND response checks.
// Each accepted sample (A, B, OUT) passes through a two-stage pipeline;
// stage 2 compares OUT against ~(A & B). Matching and mismatching samples
// are counted, and the first mismatch of a run is captured for debug.
module nand_resp_checker #(
  parameter int WIDTH   = 16,
  parameter int NUM_VEC = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] OUT,
  output logic [15:0]      PASS_CNT,
  output logic [15:0]      FAIL_CNT,
  output logic [15:0]      FF_IDX,
  output logic [WIDTH-1:0] FF_EXP,
  output logic [WIDTH-1:0] FF_GOT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t state;

  // Index handed to the next accepted sample.
  logic [15:0] vec_idx;

  // Stage 1: raw sample and its index.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_out;
  logic [15:0]      s1_idx;

  // Stage 2: expected value, observed value and the compare outcome.
  logic             s2_valid;
  logic [WIDTH-1:0] s2_exp;
  logic [WIDTH-1:0] s2_got;
  logic [15:0]      s2_idx;
  logic             s2_mismatch;

  logic             accept;
  logic             run_start;
  logic [WIDTH-1:0] s1_exp;

  // A sample is only taken while the checker advertises readiness, which
  // is only ever the case in RUN; a new run may only begin from IDLE/FIN.
  always_comb begin
    accept    = IN_VALID && IN_READY;
    run_start = START && ((state == IDLE) || (state == FIN));
    s1_exp    = ~(s1_a & s1_b);
  end

  // Run sequencing: IDLE/FIN -> RUN on START, RUN -> DRAIN on the last
  // accept, DRAIN -> FIN once stage 1 has emptied (the final compare result
  // lands in the counters on that same edge).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      vec_idx  <= '0;
      IN_READY <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            state    <= RUN;
            vec_idx  <= '0;
            IN_READY <= 1'b1;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            vec_idx <= vec_idx + 16'd1;
            if (vec_idx == LAST_IDX) begin
              state    <= DRAIN;
              IN_READY <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          IN_READY <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage compare pipeline; valid bits follow the accept handshake so
  // nothing is loaded outside RUN and a reset drops whatever is in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_out      <= '0;
      s1_idx      <= '0;
      s2_valid    <= 1'b0;
      s2_exp      <= '0;
      s2_got      <= '0;
      s2_idx      <= '0;
      s2_mismatch <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= A;
        s1_b   <= B;
        s1_out <= OUT;
        s1_idx <= vec_idx;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_exp      <= s1_exp;
        s2_got      <= s1_out;
        s2_idx      <= s1_idx;
        s2_mismatch <= (s1_exp != s1_out);
      end
    end
  end

  // Result bookkeeping: saturating pass/fail counters, sticky ERR and the
  // first-failure capture, all cleared when a new run starts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PASS_CNT <= '0;
      FAIL_CNT <= '0;
      FF_IDX   <= '0;
      FF_EXP   <= '0;
      FF_GOT   <= '0;
      ERR      <= 1'b0;
    end else if (run_start) begin
      PASS_CNT <= '0;
      FAIL_CNT <= '0;
      FF_IDX   <= '0;
      FF_EXP   <= '0;
      FF_GOT   <= '0;
      ERR      <= 1'b0;
    end else if (s2_valid) begin
      if (s2_mismatch) begin
        if (FAIL_CNT != CNT_MAX) begin
          FAIL_CNT <= FAIL_CNT + 16'd1;
        end
        ERR <= 1'b1;
        if (FAIL_CNT == 16'd0) begin
          FF_IDX <= s2_idx;
          FF_EXP <= s2_exp;
          FF_GOT <= s2_got;
        end
      end else if (PASS_CNT != CNT_MAX) begin
        PASS_CNT <= PASS_CNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_nand_resp_checker.sv
// tb_nand_resp_checker: scenario tasks checked against a behavioural model
// that derives counters, DONE and first-failure data from accept times.
module tb_nand_resp_checker;

  localparam int NV = 3;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] OUT;
  logic [15:0] PASS_CNT;
  logic [15:0] FAIL_CNT;
  logic [15:0] FF_IDX;
  logic [15:0] FF_EXP;
  logic [15:0] FF_GOT;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int total;
  int bad;

  logic [15:0] va [NV];
  logic [15:0] vb [NV];
  logic [15:0] vo [NV];

  nand_resp_checker #(.WIDTH(16), .NUM_VEC(NV)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .A(A), .B(B), .OUT(OUT),
    .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT), .FF_IDX(FF_IDX),
    .FF_EXP(FF_EXP), .FF_GOT(FF_GOT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_vectors(input logic [15:0] o0, input logic [15:0] o1, input logic [15:0] o2);
    va[0] = 16'h0000; vb[0] = 16'h68AF; vo[0] = o0;
    va[1] = 16'hFFFF; vb[1] = 16'hFF55; vo[1] = o1;
    va[2] = 16'hFFFF; vb[2] = 16'hCCCC; vo[2] = o2;
  endtask

  // Generic run: mode 0 back-to-back valid, 1 toggling valid, 2 random valid.
  // START is additionally pulsed in loop cycle start_at (ignored if < 0).
  task automatic do_run(input string name, input int mode, input int start_at);
    int acc_edge [NV];
    int n_acc;
    int cyc;
    int ep;
    int ef;
    int ffi;
    logic vld;
    logic exp_ready;
    logic exp_done;
    logic [15:0] e;
    START = 1'b1; IN_VALID = 1'b0;
    tick();
    START = 1'b0;
    total++;
    if ({IN_READY, BUSY, DONE} !== 3'b110) begin
      bad++; $display("[TB] FAIL %s run_entry_flags got=%b want=110", name, {IN_READY, BUSY, DONE});
    end
    total++;
    if ({PASS_CNT, FAIL_CNT, FF_IDX, FF_EXP, FF_GOT, ERR} !== '0) begin
      bad++; $display("[TB] FAIL %s run_entry_clear got pass=%h fail=%h idx=%h exp=%h got=%h err=%b want all 0",
                      name, PASS_CNT, FAIL_CNT, FF_IDX, FF_EXP, FF_GOT, ERR);
    end
    n_acc = 0; cyc = 0; exp_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (n_acc == NV && cyc >= acc_edge[NV-1] + 3) break;
      case (mode)
        0:       vld = 1'b1;
        1:       vld = (c % 2 == 0);
        default: vld = (c > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      exp_ready = (n_acc < NV);
      if (vld && exp_ready) begin
        A = va[n_acc]; B = vb[n_acc]; OUT = vo[n_acc];
      end else begin
        A = 16'($urandom); B = 16'($urandom); OUT = 16'($urandom);
      end
      IN_VALID = vld;
      START = (c == start_at);
      total++;
      if (IN_READY !== exp_ready) begin
        bad++; $display("[TB] FAIL %s in_ready c=%0d got=%b want=%b", name, c, IN_READY, exp_ready);
      end
      tick();
      START = 1'b0;
      cyc++;
      if (vld && exp_ready) begin
        acc_edge[n_acc] = cyc;
        n_acc++;
      end
      ep = 0; ef = 0; ffi = -1;
      for (int i = 0; i < n_acc; i++) begin
        if (acc_edge[i] + 2 <= cyc) begin
          e = ~(va[i] & vb[i]);
          if (vo[i] === e) ep++;
          else begin
            ef++;
            if (ffi < 0) ffi = i;
          end
        end
      end
      exp_done = (n_acc == NV) && (cyc >= acc_edge[NV-1] + 2);
      total++;
      if (PASS_CNT !== 16'(ep)) begin
        bad++; $display("[TB] FAIL %s pass_cnt cyc=%0d got=%0d want=%0d", name, cyc, PASS_CNT, ep);
      end
      total++;
      if (FAIL_CNT !== 16'(ef)) begin
        bad++; $display("[TB] FAIL %s fail_cnt cyc=%0d got=%0d want=%0d", name, cyc, FAIL_CNT, ef);
      end
      total++;
      if (ERR !== (ef > 0)) begin
        bad++; $display("[TB] FAIL %s err cyc=%0d got=%b want=%b", name, cyc, ERR, (ef > 0));
      end
      total++;
      if ({DONE, BUSY} !== {exp_done, !exp_done}) begin
        bad++; $display("[TB] FAIL %s done_busy cyc=%0d got=%b%b want=%b%b", name, cyc, DONE, BUSY, exp_done, !exp_done);
      end
      if (ffi >= 0) begin
        e = ~(va[ffi] & vb[ffi]);
        total++;
        if ({FF_IDX, FF_EXP, FF_GOT} !== {16'(ffi), e, vo[ffi]}) begin
          bad++; $display("[TB] FAIL %s first_fail cyc=%0d got idx=%0d exp=%h got=%h want idx=%0d exp=%h got=%h",
                          name, cyc, FF_IDX, FF_EXP, FF_GOT, ffi, e, vo[ffi]);
        end
      end
    end
    IN_VALID = 1'b0;
    total++;
    if (!exp_done || DONE !== 1'b1) begin
      bad++; $display("[TB] FAIL %s run_timeout accepts=%0d done=%b want 3 accepts and done=1", name, n_acc, DONE);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; IN_VALID = 1'b0; A = '0; B = '0; OUT = '0;
    #3;
    total++;
    if ({IN_READY, BUSY, DONE, ERR, PASS_CNT, FAIL_CNT, FF_IDX, FF_EXP, FF_GOT} !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs got rdy=%b busy=%b done=%b err=%b pass=%h fail=%h want all 0",
                      IN_READY, BUSY, DONE, ERR, PASS_CNT, FAIL_CNT);
    end
    tick(); tick();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({IN_READY, BUSY, DONE} !== 3'b000) begin
        bad++; $display("[TB] FAIL reset_idle_hold got=%b want=000", {IN_READY, BUSY, DONE});
      end
    end
  endtask

  task automatic test_all_pass();
    load_vectors(16'hFFFF, 16'h00AA, 16'h3333);
    do_run("all_pass", 0, -1);
    total++;
    if ({PASS_CNT, FAIL_CNT, ERR} !== {16'd3, 16'd0, 1'b0}) begin
      bad++; $display("[TB] FAIL all_pass_final got pass=%0d fail=%0d err=%b want 3 0 0", PASS_CNT, FAIL_CNT, ERR);
    end
  endtask

  task automatic test_one_fail();
    load_vectors(16'hFFFF, 16'h00AB, 16'h3333);
    do_run("one_fail", 0, -1);
    total++;
    if ({PASS_CNT, FAIL_CNT, FF_IDX, FF_EXP, FF_GOT, ERR} !== {16'd2, 16'd1, 16'd1, 16'h00AA, 16'h00AB, 1'b1}) begin
      bad++; $display("[TB] FAIL one_fail_final got pass=%0d fail=%0d idx=%0d exp=%h got=%h err=%b want 2 1 1 00AA 00AB 1",
                      PASS_CNT, FAIL_CNT, FF_IDX, FF_EXP, FF_GOT, ERR);
    end
  endtask

  task automatic test_all_fail();
    load_vectors(16'hFFFE, 16'h00AB, 16'h3330);
    do_run("all_fail", 0, -1);
    total++;
    if ({PASS_CNT, FAIL_CNT, FF_IDX, FF_EXP, FF_GOT} !== {16'd0, 16'd3, 16'd0, 16'hFFFF, 16'hFFFE}) begin
      bad++; $display("[TB] FAIL all_fail_final got pass=%0d fail=%0d idx=%0d exp=%h got=%h want 0 3 0 FFFF FFFE",
                      PASS_CNT, FAIL_CNT, FF_IDX, FF_EXP, FF_GOT);
    end
  endtask

  task automatic test_valid_gaps();
    load_vectors(16'hFFFF, 16'h00AA, 16'h3333);
    do_run("valid_gaps", 1, -1);
  endtask

  task automatic test_reset_mid_run();
    load_vectors(16'hFFFF, 16'h00AA, 16'h3333);
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IN_VALID = 1'b1; A = va[i]; B = vb[i]; OUT = vo[i];
      tick();
    end
    RST_N = 1'b0;
    #1;
    total++;
    if ({IN_READY, BUSY, DONE, ERR, PASS_CNT, FAIL_CNT, FF_IDX, FF_EXP, FF_GOT} !== '0) begin
      bad++; $display("[TB] FAIL mid_reset_outputs got rdy=%b busy=%b pass=%h fail=%h want all 0",
                      IN_READY, BUSY, PASS_CNT, FAIL_CNT);
    end
    IN_VALID = 1'b0;
    tick();
    RST_N = 1'b1;
    IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({IN_READY, BUSY, DONE, PASS_CNT, FAIL_CNT} !== '0) begin
        bad++; $display("[TB] FAIL mid_reset_idle got rdy=%b busy=%b done=%b pass=%0d fail=%0d want all 0",
                        IN_READY, BUSY, DONE, PASS_CNT, FAIL_CNT);
      end
    end
    IN_VALID = 1'b0;
    do_run("after_reset", 0, -1);
    total++;
    if (PASS_CNT !== 16'd3) begin
      bad++; $display("[TB] FAIL after_reset_pass got=%0d want=3", PASS_CNT);
    end
  endtask

  task automatic test_ignored_inputs();
    load_vectors(16'hFFFF, 16'h00AA, 16'h3333);
    RST_N = 1'b0;
    #1;
    RST_N = 1'b1;
    IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({IN_READY, BUSY, PASS_CNT, FAIL_CNT} !== '0) begin
        bad++; $display("[TB] FAIL idle_valid got rdy=%b busy=%b pass=%0d fail=%0d want all 0",
                        IN_READY, BUSY, PASS_CNT, FAIL_CNT);
      end
    end
    IN_VALID = 1'b0;
    do_run("start_in_run", 0, 1);
    do_run("start_in_drain", 0, 4);
  endtask

  task automatic test_random();
    logic [15:0] e;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NV; i++) begin
        va[i] = 16'($urandom);
        vb[i] = 16'($urandom);
        e = ~(va[i] & vb[i]);
        vo[i] = ($urandom_range(0, 1) == 1) ? e : (e ^ (16'd1 << $urandom_range(0, 15)));
      end
      do_run("random", r % 3, -1);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_all_pass();
    test_one_fail();
    test_all_fail();
    test_valid_gaps();
    test_reset_mid_run();
    test_ignored_inputs();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
